// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder controller.
// One full-adder cell (two half adders plus a carry OR) is reused across all
// WIDTH operand bits, LSB first, under a start/busy/done handshake. A result
// takes WIDTH+1 cycles from accepted start to the end of the done pulse.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input that turns the
// operation into a - b (two's complement: ~b with carry-in forced to 1).
module serial_adder_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       fa;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             c_load;
  logic [WIDTH-1:0] res_next;

  // Shared adder cell: two half adders, carries merged with an OR.
  // Returns {carry_out, sum_bit}.
  function automatic logic [1:0] full_add(input logic x, input logic y,
                                          input logic ci);
    logic s1;
    logic c1;
    logic s2;
    logic c2;
    s1 = x ^ y;
    c1 = x & y;
    s2 = s1 ^ ci;
    c2 = s1 & ci;
    return {c1 | c2, s2};
  endfunction

  // One bit per cycle through the single adder cell.
  always_comb begin
    fa       = full_add(a_sr[0], b_sr[0], carry);
    res_next = {fa[0], res_sr[WIDTH-1:1]};
    last_bit = (cnt == CNT_W'(WIDTH - 1));
  end

`ifdef SERIAL_ADDER_SUB_EN
  // Subtraction reuses the adder: a + ~b + 1; cin is ignored when sub is set.
  always_comb begin
    b_load = sub ? ~b : b;
    c_load = sub ? 1'b1 : cin;
  end
`else
  // Pure addition: operands load unchanged.
  always_comb begin
    b_load = b;
    c_load = cin;
  end
`endif

  // Handshake flags decode straight from the registered state.
  always_comb begin
    busy = (state == RUN) || (state == DONE);
    done = (state == DONE);
  end

  // Sequencer: capture on start, shift LSB-first in RUN, publish on last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          res_sr <= res_next;
          a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
          carry  <= fa[1];
          cnt    <= cnt + 1'b1;
          if (last_bit) begin
            sum   <= res_next;
            cout  <= fa[1];
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
